// File: rtl/tt_pin_bist.sv
// Pin-side BIST agent for a Tiny Tapeout user design: sequences its reset, drives
// LFSR vectors onto ui_in and folds uo_out into a 16-bit MISR signature.
module tt_pin_bist #(
  parameter int          NUM_VECTORS = 64,
  parameter int          SETTLE      = 2,
  parameter logic [7:0]  SEED        = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  ui_drive,
  input  logic [7:0]  uo_sample,
  output logic        dut_rst_n,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [7:0]  vec_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DUT_RST = 3'd1,
    S_APPLY   = 3'd2,
    S_SAMPLE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [3:0] SETTLE_L = 4'(SETTLE);
  localparam logic [7:0] LAST_VEC = 8'(NUM_VECTORS - 1);
  localparam logic [3:0] RST_LAST = 4'd3;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_next;
  logic [15:0] misr;
  logic [15:0] misr_next;
  logic        load_run;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_DUT_RST;
      S_DUT_RST:      if (cnt == RST_LAST) state_next = S_APPLY;
      S_APPLY:        if (cnt == SETTLE_L) state_next = S_SAMPLE;
      S_SAMPLE:       state_next = (vec_count == LAST_VEC) ? S_DONE : S_APPLY;
      default:        state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_DUT_RST, S_APPLY, S_SAMPLE: busy = 1'b1;
      S_DONE:                       done = 1'b1;
      default: ;
    endcase
  end

  assign load_run  = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign misr_next = ({misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000))
                     ^ {8'h00, uo_sample};

  // cnt restarts on every state change, so it times both DUT_RST and APPLY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      lfsr      <= 8'h00;
      misr      <= 16'h0000;
      vec_count <= 8'h00;
      dut_rst_n <= 1'b0;
    end else begin
      dut_rst_n <= (state_next != S_DUT_RST);
      if (state != state_next) cnt <= 4'd0;
      else                     cnt <= cnt + 4'd1;
      if (load_run) begin
        lfsr      <= SEED_EFF;
        misr      <= 16'hFFFF;
        vec_count <= 8'h00;
      end else if (state == S_SAMPLE) begin
        lfsr      <= lfsr_next;
        misr      <= misr_next;
        vec_count <= vec_count + 8'd1;
      end
    end
  end

  assign ui_drive  = lfsr;
  assign signature = misr;

endmodule

// File: tb/tb_tt_pin_bist.sv
// Bench for tt_pin_bist: a 64-vector instance fed by a stand-in user design and a
// 1-vector instance for the hand-computed loopback signatures.
module tb_tt_pin_bist;

  logic        clk;
  logic        rst;
  logic        start_a, start_b;
  logic        loop_b;
  logic [7:0]  ui_drive_a, ui_drive_b, uo_sample_a, uo_sample_b;
  logic        dut_rst_n_a, dut_rst_n_b, busy_a, busy_b, done_a, done_b;
  logic [15:0] signature_a, signature_b;
  logic [7:0]  vec_count_a, vec_count_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Stand-in user design: combinational XOR of the inputs.
  assign uo_sample_a = ui_drive_a ^ 8'h3C;
  assign uo_sample_b = loop_b ? ui_drive_b : 8'h00;

  tt_pin_bist #(.NUM_VECTORS(64), .SETTLE(2), .SEED(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ui_drive(ui_drive_a),
    .uo_sample(uo_sample_a), .dut_rst_n(dut_rst_n_a), .busy(busy_a),
    .done(done_a), .signature(signature_a), .vec_count(vec_count_a)
  );

  tt_pin_bist #(.NUM_VECTORS(1), .SETTLE(2), .SEED(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ui_drive(ui_drive_b),
    .uo_sample(uo_sample_b), .dut_rst_n(dut_rst_n_b), .busy(busy_b),
    .done(done_b), .signature(signature_b), .vec_count(vec_count_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          loop;
    logic [15:0] exp_sig;
    logic [7:0]  exp_cnt;
    logic [7:0]  exp_ui;
    int          exp_lat;
  } vec_t;

  vec_t       tbl[3];
  logic [7:0] lfsr_exp[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 1) start_b = v;
    else        start_a = v;
  endtask

  function automatic logic done_of(input int w);
    return (w == 1) ? done_b : done_a;
  endfunction

  // Starts a run at a falling edge and counts falling edges until done is seen.
  task automatic do_run(input int w, input bit poke, output int lat, output logic [15:0] sig);
    set_start(w, 1'b1);
    @(negedge clk);
    lat = 1;
    set_start(w, 1'b0);
    while (!done_of(w) && lat < 2000) begin
      set_start(w, (poke && (lat % 37 == 0)) ? 1'b1 : 1'b0);
      @(negedge clk);
      lat++;
    end
    set_start(w, 1'b0);
    if (lat >= 2000) check("run_timeout", 32'(lat), 32'd0);
    sig = (w == 1) ? signature_b : signature_a;
  endtask

  // Reference signature for the 64-vector instance.
  function automatic logic [15:0] sig_model(input int n);
    logic [7:0]  q;
    logic [15:0] m;
    logic [7:0]  uo;
    q = 8'hA5;
    m = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      uo = q ^ 8'h3C;
      m  = ({m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000)) ^ {8'h00, uo};
      q  = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
    return m;
  endfunction

  initial begin
    int          lat;
    logic [15:0] sig;
    logic [15:0] golden;
    int          guard;

    tbl[0] = '{loop: 1'b0, exp_sig: 16'hEFDF, exp_cnt: 8'd1, exp_ui: 8'h4A, exp_lat: 9};
    tbl[1] = '{loop: 1'b1, exp_sig: 16'hEF7A, exp_cnt: 8'd1, exp_ui: 8'h4A, exp_lat: 9};
    tbl[2] = '{loop: 1'b0, exp_sig: 16'hEFDF, exp_cnt: 8'd1, exp_ui: 8'h4A, exp_lat: 9};
    lfsr_exp[0] = 8'hA5;
    lfsr_exp[1] = 8'h4A;
    lfsr_exp[2] = 8'h95;
    lfsr_exp[3] = 8'h2A;
    golden = sig_model(64);

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; loop_b = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs_a", {busy_a, done_a, dut_rst_n_a, ui_drive_a, signature_a, vec_count_a}, 32'd0);
    check("rst_outputs_b", {busy_b, done_b, dut_rst_n_b, ui_drive_b, signature_b, vec_count_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_dut_rst_n_a", 32'(dut_rst_n_a), 32'd1);
    check("rst_release_dut_rst_n_b", 32'(dut_rst_n_b), 32'd1);
    check("idle_busy_done_a", {busy_a, done_a}, 32'd0);

    // Table-driven single-vector signatures on instance b
    foreach (tbl[i]) begin
      loop_b = tbl[i].loop;
      do_run(1, 1'b0, lat, sig);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("tbl%0d_signature", i), 32'(sig), 32'(tbl[i].exp_sig));
      check($sformatf("tbl%0d_vec_count", i), 32'(vec_count_b), 32'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_ui_drive", i), 32'(ui_drive_b), 32'(tbl[i].exp_ui));
      check($sformatf("tbl%0d_busy_rstn", i), {busy_b, dut_rst_n_b}, 32'd1);
    end

    // start held high: back-to-back runs, each DONE lasting one cycle
    loop_b = 1'b0;
    start_b = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      check($sformatf("held_done_n%0d", n), 32'(done_b), 32'(n % 9 == 0));
      check($sformatf("held_rstn_n%0d", n), 32'(dut_rst_n_b),
            32'(!((n >= 1 && n <= 4) || (n >= 10 && n <= 13))));
    end
    start_b = 1'b0;
    check("held_signature", 32'(signature_b), 32'hEFDF);

    // LFSR sequence and DUT reset window on the 64-vector instance
    start_a = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start_a = 1'b0;
      check($sformatf("seq_rstn_n%0d", n), 32'(dut_rst_n_a), 32'(n >= 5));
      if (n >= 5) begin
        check($sformatf("seq_ui_n%0d", n), 32'(ui_drive_a), 32'(lfsr_exp[(n - 5) / 4]));
        if ((n - 5) % 4 == 0)
          check($sformatf("seq_vec_count_n%0d", n), 32'(vec_count_a), 32'((n - 5) / 4));
      end
    end
    lat = 20;
    while (!done_a && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check("full_latency", 32'(lat), 32'd261);
    check("full_signature", 32'(signature_a), 32'(golden));
    check("full_vec_count", 32'(vec_count_a), 32'd64);

    // start pulses while busy are ignored; start in DONE restarts cleanly
    do_run(0, 1'b1, lat, sig);
    check("poke_latency", 32'(lat), 32'd261);
    check("poke_signature", 32'(sig), 32'(golden));

    // Asynchronous reset mid-run at vector 10
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    guard = 0;
    while (vec_count_a != 8'd10 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("midrun_reach_vec10", 32'(vec_count_a), 32'd10);
    #2 rst = 1'b1;
    #1;
    check("midrun_async_zero", {busy_a, done_a, dut_rst_n_a, ui_drive_a, signature_a, vec_count_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrun_idle", {busy_a, done_a, dut_rst_n_a}, 32'd1);
    do_run(0, 1'b0, lat, sig);
    check("midrun_latency", 32'(lat), 32'd261);
    check("midrun_signature", 32'(sig), 32'(golden));

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_pin_bist.md
# tt_pin_bist

Built-in self-test agent that exercises a Tiny Tapeout user design from the pin side. It drives pseudo-random vectors onto the design's dedicated inputs (`ui_in`) and compresses the design's dedicated outputs (`uo_out`) into a 16-bit signature. It also sequences the design's active-low reset. It sits between the lab top level and a `tt_um_*` user project, taking the role the simulation bench plays, so silicon runs can be checked against a golden signature.

## Interface
- `NUM_VECTORS`, default 64: vectors per run. Legal range 1..255.
- `SETTLE`, default 2: extra wait cycles between applying a vector and sampling. Legal range 0..15.
- `SEED`, default 8'hA5: LFSR start value. A value of 0 is replaced by 8'h01.

Ports:
- `clk`  in  1: single clock. Everything is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a run. Sampled only in IDLE or DONE.
- `ui_drive`  out  8: vector to the DUT's `ui_in`. Registered.
- `uo_sample`  in  8: the DUT's `uo_out`.
- `dut_rst_n`  out  1: active-low reset to the DUT. Registered.
- `busy`  out  1: high from DUT_RST through the final SAMPLE.
- `done`  out  1: high in DONE. Marks `signature` as valid.
- `signature`  out  16: MISR contents.
- `vec_count`  out  8: vectors sampled so far in the current run.

## Operation
- States: IDLE, DUT_RST, APPLY, SAMPLE, DONE.
- While `rst` is high, all outputs are 0 and the state is IDLE. This holds at any time, including mid-run, and aborts the run. Counters and LFSR clear.
- IDLE: `dut_rst_n`=1, `busy`=0, `done`=0.
- IDLE or DONE with `start`=1:
  - Go to DUT_RST.
  - Load LFSR = SEED, `ui_drive` = SEED, MISR = 16'hFFFF, `vec_count` = 0.
  - `done` drops.
- DUT_RST: `dut_rst_n`=0 for exactly 4 cycles, then go to APPLY.
- APPLY: `dut_rst_n`=1 and `ui_drive` holds the current vector. Lasts 1+SETTLE cycles, then go to SAMPLE.
- SAMPLE (1 cycle), with updates registered at its closing edge:
  - MISR feedback fb = m[15].
  - next MISR = ({m[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0)) ^ {8'h00, `uo_sample`}.
  - `vec_count` increments.
  - LFSR advances and the new value is loaded to `ui_drive`.
  - If `vec_count`+1 == NUM_VECTORS, go to DONE; otherwise go to APPLY.
- LFSR: 8-bit. next = {q[6:0], q[7]^q[5]^q[4]^q[3]}. It never reaches 0.
- DONE:
  - `done`=1, `busy`=0.
  - `signature` and `vec_count` hold.
  - `ui_drive` holds the post-advance vector.
  - `dut_rst_n`=1.
- `start` asserted while `busy` is ignored.
- `start` held high continuously causes back-to-back runs: each DONE lasts exactly 1 cycle.
- `signature` always reflects the live MISR register.

## Timing
- Let `start` be sampled at edge k. DUT_RST occupies cycles k+1..k+4 and the first APPLY begins at k+5.
- Each vector takes SETTLE+2 cycles.
- `done` rises at edge k+5+NUM_VECTORS*(SETTLE+2).
- With the defaults, `done` rises at k+261.
- `uo_sample` is sampled only in SAMPLE, at least SETTLE+1 cycles after `ui_drive` changed. The DUT's combinational or one-cycle-registered response must be stable by then.
- No combinational path from `uo_sample` or `start` to any output.

## Test plan
- Reset check: assert `rst` for 3 cycles, then release. All outputs are 0, including `dut_rst_n`. `dut_rst_n` goes to 1 on the first edge after release.
- LFSR sequence: use SEED=8'hA5 with `uo_sample` tied to 0. `ui_drive` shows A5, 4A, 95, 2A on successive vectors. Each value persists SETTLE+2 cycles.
- Zero-loopback signature: NUM_VECTORS=1 with `uo_sample`=0. Required results:
  - `signature`=16'hEFDF.
  - `vec_count`=1.
  - `done` at k+9 for SETTLE=2.
- Identity loopback: NUM_VECTORS=1 with `uo_sample`=`ui_drive` (A5). `signature`=16'hEF7A.
- Reset mid-run: at vector 10 of 64, pulse `rst` for 1 cycle. Required results:
  - Outputs are 0 immediately, without waiting for a clock edge.
  - `start` then yields the same signature as an uninterrupted run.
- Restart and ignore:
  - Pulse `start` while `busy`: no effect on timing or signature.
  - `start` in DONE: `done` drops the next cycle and DUT_RST repeats for 4 cycles.
  - Result: identical signature.
